// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, requests words from instruction memory and hands them to decode.
// Optional performance counters (fetch_cnt_o / stall_cnt_o) are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        halt_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] pc_o,
    output logic        fetch_err_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    typedef enum logic [2:0] {S_BOOT, S_REQ, S_OUT, S_DROP, S_ERR} state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] redir_tgt;
    logic        timeout;
    logic        fetch_ok;
    logic        stall;
    logic        unused_lsbs;

    assign redir_tgt   = {redirect_pc_i[31:2], 2'b00};
    assign unused_lsbs = ^redirect_pc_i[1:0];
    assign timeout     = (wait_q == WAIT_LIMIT);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state     <= S_BOOT;
            pc        <= RESET_PC;
            tgt_q     <= '0;
            inst_q    <= NOP_INST;
            inst_pc_q <= '0;
            wait_q    <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            tgt_q     <= tgt_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        tgt_d        = tgt_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        wait_d       = wait_q;
        fetch_ok     = 1'b0;
        stall        = 1'b0;
        mem_req_o    = 1'b0;
        inst_valid_o = 1'b0;
        fetch_err_o  = 1'b0;
        case (state)
            S_BOOT: begin
                if (!halt_i) begin
                    state_d = S_REQ;
                    wait_d  = '0;
                end
            end
            S_REQ: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    wait_d = '0;
                    if (redirect_i) begin
                        pc_d = redir_tgt;
                    end else begin
                        inst_d    = mem_rdata_i;
                        inst_pc_d = pc;
                        pc_d      = pc + 32'd4;
                        state_d   = S_OUT;
                        fetch_ok  = 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                    // Watchdog expiry takes precedence over a redirect arriving the same cycle.
                    if (timeout) begin
                        state_d = S_ERR;
                    end else if (redirect_i) begin
                        tgt_d   = redir_tgt;
                        state_d = S_DROP;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            S_DROP: begin
                mem_req_o = 1'b1;
                if (redirect_i) begin
                    tgt_d = redir_tgt;
                end
                if (mem_ready_i) begin
                    pc_d    = redirect_i ? redir_tgt : tgt_q;
                    wait_d  = '0;
                    state_d = halt_i ? S_BOOT : S_REQ;
                end else begin
                    stall = 1'b1;
                    if (timeout) begin
                        state_d = S_ERR;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            S_OUT: begin
                inst_valid_o = 1'b1;
                if (redirect_i || inst_ready_i) begin
                    if (redirect_i) begin
                        pc_d = redir_tgt;
                    end
                    wait_d  = '0;
                    state_d = halt_i ? S_BOOT : S_REQ;
                end
            end
            S_ERR: begin
                fetch_err_o = 1'b1;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign mem_addr_o = pc;
    assign pc_o       = pc;
    assign inst_pc_o  = inst_pc_q;
    assign inst_o     = (state == S_OUT) ? inst_q : NOP_INST;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (fetch_ok) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            if (stall) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = fetch_ok ^ stall;
`endif

endmodule
